// File: rtl/tone_gen_pkg.sv
// Shared constants for the tone generator: LFSR geometry, seed and noise bit map.
package tone_gen_pkg;

   localparam int LFSR_BITS = 23;
   localparam logic [LFSR_BITS-1:0] LFSR_SEED = 23'h7FFFF8;
   localparam int LFSR_TAP_HI = 22;
   localparam int LFSR_TAP_LO = 17;

   // LFSR bits routed to noise[7:0], MSB first
   localparam int NOISE_MAP [8] = '{22, 20, 16, 13, 11, 7, 4, 2};

endpackage

// File: rtl/tone_phase_accumulator_if.sv
// Frequency-word valid/ready handshake between a control source and a voice.
interface tone_phase_accumulator_if #(
   parameter int FREQ_BITS = 16
);
   logic [FREQ_BITS-1:0] freq_data;
   logic                 freq_valid;
   logic                 freq_ready;

   modport master (output freq_data, output freq_valid, input freq_ready);
   modport slave  (input freq_data, input freq_valid, output freq_ready);
endinterface

// File: rtl/tone_phase_accumulator_noise_lfsr.sv
// 23-bit SID-style noise LFSR; exposes the eight tapped bits as an 8-bit noise sample.
module noise_lfsr
   import tone_gen_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step,
   input  logic       hold_seed,
   output logic [7:0] noise
);

   logic [LFSR_BITS-1:0] lfsr_q;

   // Seed load wins over a step so test mode always leaves a known state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lfsr_q <= LFSR_SEED;
      else if (hold_seed)
         lfsr_q <= LFSR_SEED;
      else if (step)
         lfsr_q <= {lfsr_q[LFSR_BITS-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
   end

   // Gather the scattered tap bits into the noise sample
   always_comb begin
      noise = '0;
      for (int i = 0; i < 8; i++)
         noise[7-i] = lfsr_q[NOISE_MAP[i]];
   end

endmodule

// File: rtl/tone_phase_accumulator.sv
// Per-voice phase accumulator with double-buffered frequency word, hard sync,
// test/hold, MSB-rise/wrap pulses and an LFSR noise source.
module tone_phase_accumulator
   import tone_gen_pkg::*;
#(
   parameter int ACCUMULATOR_BITS = 24,
   parameter int FREQ_BITS        = 16,
   parameter int OUTPUT_BITS      = 12,
   parameter int NOISE_CLK_BIT    = 19
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sample_tick,
   tone_phase_accumulator_if.slave     freq_bus,
   input  logic                        test,
   input  logic                        en_sync,
   input  logic                        sync_in,
   output logic [ACCUMULATOR_BITS-1:0] accumulator,
   output logic                        msb_rise,
   output logic                        wrap,
   output logic [OUTPUT_BITS-1:0]      noise_out
);

   localparam int MSB = ACCUMULATOR_BITS - 1;

   logic [1:0]                  rst_sync_q;
   logic                        rst_int_n;
   logic [ACCUMULATOR_BITS-1:0] acc_q, acc_d, inc;
   logic [ACCUMULATOR_BITS:0]   sum;
   logic [FREQ_BITS-1:0]        active_q, pend_q;
   logic                        pend_full_q, sync_pend_q, msb_rise_q, wrap_q;
   logic                        carry, sync_event, accept, lfsr_step;
   logic [7:0]                  noise8;

   // Reset asserts immediately but releases only on a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   assign freq_bus.freq_ready = !pend_full_q;
   assign accept     = freq_bus.freq_valid && !pend_full_q;
   assign sync_event = sync_pend_q || (sync_in && en_sync);

   // A buffered word is used by the very tick that promotes it
   assign inc = ACCUMULATOR_BITS'(pend_full_q ? pend_q : active_q);
   assign sum = {1'b0, acc_q} + {1'b0, inc};

   // Next phase: test and sync both zero the phase without adding
   always_comb begin
      acc_d = acc_q;
      carry = 1'b0;
      if (sample_tick) begin
         if (test || sync_event)
            acc_d = '0;
         else
            {carry, acc_d} = sum;
      end
   end

   assign lfsr_step = sample_tick && !test && !acc_q[NOISE_CLK_BIT] && acc_d[NOISE_CLK_BIT];

   // Phase register and the one-cycle edge pulses derived from each tick
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         acc_q      <= '0;
         msb_rise_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         msb_rise_q <= sample_tick && !acc_q[MSB] && acc_d[MSB];
         wrap_q     <= carry;
      end
   end

   // Frequency double buffer: accept only when empty, promote on tick
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         active_q    <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
      end else if (accept) begin
         pend_q      <= freq_bus.freq_data;
         pend_full_q <= 1'b1;
      end else if (sample_tick && pend_full_q) begin
         active_q    <= pend_q;
         pend_full_q <= 1'b0;
      end
   end

   // Sync latch: remembers an enabled sync pulse until the next tick
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)            sync_pend_q <= 1'b0;
      else if (sample_tick)      sync_pend_q <= 1'b0;
      else if (sync_in && en_sync) sync_pend_q <= 1'b1;
   end

   noise_lfsr u_noise (
      .clk       (clk),
      .rst_n     (rst_int_n),
      .step      (lfsr_step),
      .hold_seed (sample_tick && test),
      .noise     (noise8)
   );

   generate
      if (OUTPUT_BITS > 8) begin : g_pad
         assign noise_out = {noise8, {(OUTPUT_BITS-8){1'b0}}};
      end else begin : g_nopad
         assign noise_out = noise8;
      end
   endgenerate

   assign accumulator = acc_q;
   assign msb_rise    = msb_rise_q;
   assign wrap        = wrap_q;

endmodule
